// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Purpose  : Architectural register file at the writeback end of the integer
//            pipeline: 31 general registers plus a hard-wired zero register,
//            and the HI/LO pair. Two combinational GPR read ports for decode
//            and one combinational HI/LO read port for execute. Every read
//            port bypasses the write happening in the same cycle.
// Ports    : clk            - single clock, state updates on rising edge
//            rst            - asynchronous active-high reset
//            we/waddr/wdata - GPR write port (from writeback)
//            re1/raddr1     - GPR read port 1 enable/address -> rdata1
//            re2/raddr2     - GPR read port 2 enable/address -> rdata2
//            whilo/hi_i/lo_i- HI/LO write port (both halves together)
//            hi_o/lo_o      - HI/LO read data, bypassed
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   input  logic              whilo,
   input  logic [DATA_W-1:0] hi_i,
   input  logic [DATA_W-1:0] lo_i,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   // Register 0 is not stored, so the array starts at index 1.
   localparam int NREGS = (1 << ADDR_W) - 1;

   logic [DATA_W-1:0] r_regs [1:NREGS];
   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;

   logic [DATA_W-1:0] w_stored1;
   logic [DATA_W-1:0] w_stored2;

   // ------------------------------------------------------------------------
   // GPR storage. A write addressed to r0 matches no entry and is dropped.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i <= NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = 1; i <= NREGS; i++) begin
            if (we && (waddr == ADDR_W'(i))) begin
               r_regs[i] <= wdata;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // HI/LO storage: both halves always update together.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (whilo) begin
         r_hi <= hi_i;
         r_lo <= lo_i;
      end
   end

   // ------------------------------------------------------------------------
   // Stored-value lookup by address compare rather than direct indexing, so
   // address 0 never indexes outside the array and naturally yields zero.
   // ------------------------------------------------------------------------
   always_comb begin
      w_stored1 = '0;
      w_stored2 = '0;
      for (int i = 1; i <= NREGS; i++) begin
         if (raddr1 == ADDR_W'(i)) begin
            w_stored1 = r_regs[i];
         end
         if (raddr2 == ADDR_W'(i)) begin
            w_stored2 = r_regs[i];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Read port 1: reset, r0, bypass, stored, disabled -- in that priority.
   // ------------------------------------------------------------------------
   always_comb begin
      rdata1 = '0;
      if (rst) begin
         rdata1 = '0;
      end else if (raddr1 == '0) begin
         rdata1 = '0;
      end else if (re1 && we && (waddr == raddr1)) begin
         rdata1 = wdata;
      end else if (re1) begin
         rdata1 = w_stored1;
      end
   end

   // ------------------------------------------------------------------------
   // Read port 2: same priority as port 1, fully independent.
   // ------------------------------------------------------------------------
   always_comb begin
      rdata2 = '0;
      if (rst) begin
         rdata2 = '0;
      end else if (raddr2 == '0) begin
         rdata2 = '0;
      end else if (re2 && we && (waddr == raddr2)) begin
         rdata2 = wdata;
      end else if (re2) begin
         rdata2 = w_stored2;
      end
   end

   // ------------------------------------------------------------------------
   // HI/LO read with same-cycle bypass of the incoming pair.
   // ------------------------------------------------------------------------
   always_comb begin
      hi_o = '0;
      lo_o = '0;
      if (rst) begin
         hi_o = '0;
         lo_o = '0;
      end else if (whilo) begin
         hi_o = hi_i;
         lo_o = lo_i;
      end else begin
         hi_o = r_hi;
         lo_o = r_lo;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Purpose  : Self-checking bench for wb_regfile. Directed scenarios plus a
//            randomized phase, all compared against an array-based model of
//            the architectural state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        re1;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;
   logic        whilo;
   logic [31:0] hi_i;
   logic [31:0] lo_i;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int checks;
   int failures;

   // Reference state: architectural register contents and HI/LO.
   logic [31:0] m_regs [32];
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk    (clk),
      .rst    (rst),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .re1    (re1),
      .raddr1 (raddr1),
      .rdata1 (rdata1),
      .re2    (re2),
      .raddr2 (raddr2),
      .rdata2 (rdata2),
      .whilo  (whilo),
      .hi_i   (hi_i),
      .lo_i   (lo_i),
      .hi_o   (hi_o),
      .lo_o   (lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
      if (rst)                       return 32'h0;
      if (a == 5'd0)                 return 32'h0;
      if (re && we && (waddr == a))  return wdata;
      if (re)                        return m_regs[a];
      return 32'h0;
   endfunction

   function automatic logic [31:0] exp_hi();
      if (rst)   return 32'h0;
      if (whilo) return hi_i;
      return m_hi;
   endfunction

   function automatic logic [31:0] exp_lo();
      if (rst)   return 32'h0;
      if (whilo) return lo_i;
      return m_lo;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_hi = 32'h0;
      m_lo = 32'h0;
   endtask

   // Advance one clock: commit the model at the rising edge, return at the
   // following falling edge where inputs are changed and outputs sampled.
   task automatic step();
      @(posedge clk);
      if (!rst) begin
         if (we && (waddr != 5'd0)) m_regs[waddr] = wdata;
         if (whilo) begin
            m_hi = hi_i;
            m_lo = lo_i;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      we = 1'b0; waddr = 5'd0; wdata = 32'h0;
      re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
      whilo = 1'b0; hi_i = 32'h0; lo_i = 32'h0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      // outputs while reset is held from time zero
      #1;
      checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
         failures++;
         $display("FAIL reset_initial: rd1=%h rd2=%h hi=%h lo=%h expected all 0", rdata1, rdata2, hi_o, lo_o);
      end
      @(negedge clk);
      rst = 1'b0;
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      whilo = 1'b1; hi_i = 32'h1; lo_i = 32'h2;
      step();
      idle_inputs();
      re1 = 1'b1; raddr1 = 5'd5;
      #1;
      checks++;
      if (rdata1 !== 32'hDEADBEEF || hi_o !== 32'h1 || lo_o !== 32'h2) begin
         failures++;
         $display("FAIL reset_prewrite: rd1=%h hi=%h lo=%h expected deadbeef/1/2", rdata1, hi_o, lo_o);
      end
      // assert reset between edges: outputs drop immediately
      rst = 1'b1;
      model_clear();
      #1;
      checks++;
      if (rdata1 !== 32'h0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
         failures++;
         $display("FAIL reset_async: rd1=%h hi=%h lo=%h expected 0/0/0", rdata1, hi_o, lo_o);
      end
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (rdata1 !== 32'h0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
         failures++;
         $display("FAIL reset_cleared: rd1=%h hi=%h lo=%h expected 0/0/0", rdata1, hi_o, lo_o);
      end
      @(negedge clk);
   endtask

   task automatic test_write_readback();
      for (int i = 1; i < 32; i++) begin
         we = 1'b1; waddr = 5'(i); wdata = 32'h100 + 32'(i);
         step();
      end
      idle_inputs();
      re1 = 1'b1; raddr1 = 5'd1; re2 = 1'b1; raddr2 = 5'd31;
      #1;
      checks++;
      if (rdata1 !== 32'h101 || rdata2 !== 32'h11F) begin
         failures++;
         $display("FAIL readback_1_31: rd1=%h rd2=%h expected 101/11f", rdata1, rdata2);
      end
      raddr1 = 5'd16; raddr2 = 5'd16;
      #1;
      checks++;
      if (rdata1 !== 32'h110 || rdata2 !== 32'h110) begin
         failures++;
         $display("FAIL readback_16_16: rd1=%h rd2=%h expected 110/110", rdata1, rdata2);
      end
      re1 = 1'b0;
      #1;
      checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h110) begin
         failures++;
         $display("FAIL readback_re1_off: rd1=%h rd2=%h expected 0/110", rdata1, rdata2);
      end
      // sweep all registers on both ports against the model
      re1 = 1'b1;
      for (int i = 0; i < 32; i++) begin
         raddr1 = 5'(i); raddr2 = 5'(31 - i);
         #1;
         checks++;
         if (rdata1 !== exp_rd(re1, raddr1) || rdata2 !== exp_rd(re2, raddr2)) begin
            failures++;
            $display("FAIL readback_sweep[%0d]: rd1=%h rd2=%h expected %h/%h", i, rdata1, rdata2,
                     exp_rd(re1, raddr1), exp_rd(re2, raddr2));
         end
      end
      @(negedge clk);
   endtask

   task automatic test_r0();
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
      re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
      #1;
      checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
         failures++;
         $display("FAIL r0_bypass: rd1=%h rd2=%h expected 0/0", rdata1, rdata2);
      end
      step();
      we = 1'b0;
      #1;
      checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
         failures++;
         $display("FAIL r0_stored: rd1=%h rd2=%h expected 0/0", rdata1, rdata2);
      end
      // the dropped write must not land in any other register
      raddr1 = 5'd1; raddr2 = 5'd31;
      #1;
      checks++;
      if (rdata1 !== 32'h101 || rdata2 !== 32'h11F) begin
         failures++;
         $display("FAIL r0_no_alias: rd1=%h rd2=%h expected 101/11f", rdata1, rdata2);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_gpr_bypass();
      we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
      step();
      wdata = 32'h22222222;
      re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
      #1;
      checks++;
      if (rdata1 !== 32'h22222222 || rdata2 !== 32'h22222222) begin
         failures++;
         $display("FAIL bypass_same: rd1=%h rd2=%h expected 22222222/22222222", rdata1, rdata2);
      end
      step();
      we = 1'b0;
      #1;
      checks++;
      if (rdata1 !== 32'h22222222 || rdata2 !== 32'h22222222) begin
         failures++;
         $display("FAIL bypass_commit: rd1=%h rd2=%h expected 22222222/22222222", rdata1, rdata2);
      end
      we = 1'b1; wdata = 32'h33333333; raddr2 = 5'd8;
      #1;
      checks++;
      if (rdata1 !== 32'h33333333 || rdata2 !== 32'h108) begin
         failures++;
         $display("FAIL bypass_other_port: rd1=%h rd2=%h expected 33333333/108", rdata1, rdata2);
      end
      // bypass only applies when the port is enabled
      re1 = 1'b0;
      #1;
      checks++;
      if (rdata1 !== 32'h0) begin
         failures++;
         $display("FAIL bypass_disabled: rd1=%h expected 0", rdata1);
      end
      step();
      idle_inputs();
   endtask

   task automatic test_hilo();
      whilo = 1'b1; hi_i = 32'hAAAA0000; lo_i = 32'h0000BBBB;
      #1;
      checks++;
      if (hi_o !== 32'hAAAA0000 || lo_o !== 32'h0000BBBB) begin
         failures++;
         $display("FAIL hilo_bypass: hi=%h lo=%h expected aaaa0000/0000bbbb", hi_o, lo_o);
      end
      step();
      whilo = 1'b0; hi_i = 32'h12345678; lo_i = 32'h9ABCDEF0;
      #1;
      checks++;
      if (hi_o !== 32'hAAAA0000 || lo_o !== 32'h0000BBBB) begin
         failures++;
         $display("FAIL hilo_hold: hi=%h lo=%h expected aaaa0000/0000bbbb", hi_o, lo_o);
      end
      step();
      whilo = 1'b1; hi_i = 32'hCAFE0001; lo_i = 32'hF00D0002;
      we = 1'b1; waddr = 5'd3; wdata = 32'h0BADC0DE;
      step();
      idle_inputs();
      re1 = 1'b1; raddr1 = 5'd3;
      #1;
      checks++;
      if (hi_o !== 32'hCAFE0001 || lo_o !== 32'hF00D0002 || rdata1 !== 32'h0BADC0DE) begin
         failures++;
         $display("FAIL hilo_gpr_both: hi=%h lo=%h r3=%h expected cafe0001/f00d0002/0badc0de", hi_o, lo_o, rdata1);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         we = 1'($urandom); waddr = 5'($urandom); wdata = $urandom;
         re1 = 1'($urandom_range(0, 3) != 0); raddr1 = 5'($urandom);
         re2 = 1'($urandom_range(0, 3) != 0); raddr2 = 5'($urandom);
         // bias toward hazards so bypass paths are exercised often
         if ($urandom_range(0, 3) == 0) raddr1 = waddr;
         if ($urandom_range(0, 3) == 0) raddr2 = waddr;
         whilo = 1'($urandom); hi_i = $urandom; lo_i = $urandom;
         #1;
         checks++;
         if (rdata1 !== exp_rd(re1, raddr1) || rdata2 !== exp_rd(re2, raddr2) ||
             hi_o !== exp_hi() || lo_o !== exp_lo()) begin
            failures++;
            $display("FAIL random[%0d]: rd1=%h rd2=%h hi=%h lo=%h expected %h/%h/%h/%h", n,
                     rdata1, rdata2, hi_o, lo_o, exp_rd(re1, raddr1), exp_rd(re2, raddr2),
                     exp_hi(), exp_lo());
         end
         step();
      end
      idle_inputs();
   endtask

   task automatic test_reset_overlap();
      we = 1'b1; waddr = 5'd4; wdata = 32'h5;
      rst = 1'b1;
      model_clear();
      step();
      rst = 1'b0;
      we = 1'b0;
      re1 = 1'b1; raddr1 = 5'd4;
      #1;
      checks++;
      if (rdata1 !== 32'h0) begin
         failures++;
         $display("FAIL reset_overlap: r4=%h expected 0", rdata1);
      end
      // first write after release lands on the next edge
      we = 1'b1; wdata = 32'h9;
      step();
      we = 1'b0;
      #1;
      checks++;
      if (rdata1 !== 32'h9) begin
         failures++;
         $display("FAIL reset_first_write: r4=%h expected 9", rdata1);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      idle_inputs();
      model_clear();
      test_reset();
      test_write_readback();
      test_r0();
      test_gpr_bypass();
      test_hilo();
      test_random();
      test_reset_overlap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
